// File: rtl/bcd_rtc_core.sv
`default_nettype none
// ============================================================================
// Module  : bcd_rtc_core
// Brief   : BCD real-time clock with prescaler, validated load, 12/24 h mode,
//           day-wrap pulse and hh:mm alarm with acknowledge.
// Revision: 1.0
// ============================================================================
module bcd_rtc_core #(
    parameter int CLK_DIV = 1,
    parameter int HOUR_12 = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [23:0] set_time,
    input  logic        set_pm,
    input  logic [15:0] alarm_time,
    input  logic        alarm_pm,
    input  logic        alarm_en,
    input  logic        alarm_ack,
    output logic [3:0]  sec1,
    output logic [3:0]  sec0,
    output logic [3:0]  min1,
    output logic [3:0]  min0,
    output logic [3:0]  hour1,
    output logic [3:0]  hour0,
    output logic        pm,
    output logic        sec_tick,
    output logic        day_wrap,
    output logic        alarm,
    output logic        load_err
);
    localparam int              c_CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);
    localparam logic [7:0]      c_RST_HOURS = (HOUR_12 != 0) ? 8'h12 : 8'h00;

    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0] r_s0, r_s1, r_m0, r_m1, r_h0, r_h1;
    logic       r_pm, r_sec_tick, r_day_wrap, r_alarm, r_load_err;

    logic [3:0] w_n_s0, w_n_s1, w_n_m0, w_n_m1, w_n_h0, w_n_h1;
    logic       w_n_pm, w_wrap, w_tick, w_load_ok, w_alarm_hit, w_alarm_clr;
    logic [7:0] w_set_hours;

    assign w_tick      = en && (r_cnt == c_CNT_MAX);
    assign w_set_hours = set_time[23:16];

    // BCD digits compare like binary once each digit is known to be <= 9.
    always_comb begin
        w_load_ok = (set_time[23:20] <= 4'd9) && (set_time[19:16] <= 4'd9) &&
                    (set_time[15:12] <= 4'd5) && (set_time[11:8]  <= 4'd9) &&
                    (set_time[7:4]   <= 4'd5) && (set_time[3:0]   <= 4'd9);
        if (HOUR_12 != 0) begin
            w_load_ok = w_load_ok && (w_set_hours >= 8'h01) && (w_set_hours <= 8'h12);
        end else begin
            w_load_ok = w_load_ok && (w_set_hours <= 8'h23);
        end
    end

    always_comb begin
        w_n_s0 = r_s0 + 4'd1;
        w_n_s1 = r_s1;
        w_n_m0 = r_m0;
        w_n_m1 = r_m1;
        w_n_h0 = r_h0;
        w_n_h1 = r_h1;
        w_n_pm = r_pm;
        w_wrap = 1'b0;
        if (r_s0 == 4'd9) begin
            w_n_s0 = 4'd0;
            w_n_s1 = r_s1 + 4'd1;
            if (r_s1 == 4'd5) begin
                w_n_s1 = 4'd0;
                w_n_m0 = r_m0 + 4'd1;
                if (r_m0 == 4'd9) begin
                    w_n_m0 = 4'd0;
                    w_n_m1 = r_m1 + 4'd1;
                    if (r_m1 == 4'd5) begin
                        w_n_m1 = 4'd0;
                        if (HOUR_12 != 0) begin
                            // 11 -> 12 flips am/pm; only pm -> am is a new day.
                            if ({r_h1, r_h0} == 8'h12) begin
                                {w_n_h1, w_n_h0} = 8'h01;
                            end else if ({r_h1, r_h0} == 8'h11) begin
                                {w_n_h1, w_n_h0} = 8'h12;
                                w_n_pm = ~r_pm;
                                w_wrap = r_pm;
                            end else if (r_h0 == 4'd9) begin
                                w_n_h0 = 4'd0;
                                w_n_h1 = r_h1 + 4'd1;
                            end else begin
                                w_n_h0 = r_h0 + 4'd1;
                            end
                        end else begin
                            if ({r_h1, r_h0} == 8'h23) begin
                                {w_n_h1, w_n_h0} = 8'h00;
                                w_wrap = 1'b1;
                            end else if (r_h0 == 4'd9) begin
                                w_n_h0 = 4'd0;
                                w_n_h1 = r_h1 + 4'd1;
                            end else begin
                                w_n_h0 = r_h0 + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign w_alarm_hit = alarm_en && (w_n_s1 == 4'd0) && (w_n_s0 == 4'd0) &&
                         ({w_n_h1, w_n_h0, w_n_m1, w_n_m0} == alarm_time) &&
                         ((HOUR_12 == 0) || (w_n_pm == alarm_pm));
    assign w_alarm_clr = alarm_ack || !alarm_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt                        <= '0;
            {r_h1, r_h0}                 <= c_RST_HOURS;
            {r_m1, r_m0, r_s1, r_s0}     <= 16'h0000;
            r_pm                         <= 1'b0;
            r_sec_tick                   <= 1'b0;
            r_day_wrap                   <= 1'b0;
            r_alarm                      <= 1'b0;
            r_load_err                   <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            r_day_wrap <= 1'b0;
            r_load_err <= 1'b0;
            if (load && w_load_ok) begin
                {r_h1, r_h0, r_m1, r_m0, r_s1, r_s0} <= set_time;
                r_pm  <= (HOUR_12 != 0) ? set_pm : 1'b0;
                r_cnt <= '0;
                if (w_alarm_clr) begin
                    r_alarm <= 1'b0;
                end
            end else begin
                r_load_err <= load;
                if (en) begin
                    r_cnt <= w_tick ? '0 : r_cnt + c_CNT_W'(1);
                end
                if (w_tick) begin
                    {r_h1, r_h0, r_m1, r_m0, r_s1, r_s0} <=
                        {w_n_h1, w_n_h0, w_n_m1, w_n_m0, w_n_s1, w_n_s0};
                    r_pm       <= w_n_pm;
                    r_sec_tick <= 1'b1;
                    r_day_wrap <= w_wrap;
                end
                if (w_tick && w_alarm_hit) begin
                    r_alarm <= 1'b1;
                end else if (w_alarm_clr) begin
                    r_alarm <= 1'b0;
                end
            end
        end
    end

    assign sec1     = r_s1;
    assign sec0     = r_s0;
    assign min1     = r_m1;
    assign min0     = r_m0;
    assign hour1    = r_h1;
    assign hour0    = r_h0;
    assign pm       = r_pm;
    assign sec_tick = r_sec_tick;
    assign day_wrap = r_day_wrap;
    assign alarm    = r_alarm;
    assign load_err = r_load_err;
endmodule
`default_nettype wire

// File: tb/tb_bcd_rtc_core.sv
`default_nettype none
// Three cores (div4/24h, div1/24h, div1/12h) share stimulus; a seconds-of-day
// reference model predicts every output of each core every cycle.
module tb_bcd_rtc_core;
    logic        clk = 1'b0;
    logic        rst, en, load, set_pm, alarm_pm, alarm_en, alarm_ack;
    logic [23:0] set_time;
    logic [15:0] alarm_time;
    wire  [28:0] o0, o1, o2;
    logic [28:0] obs [3];
    int          checks = 0;
    int          errors = 0;

    int   m_tod [3];
    int   m_cnt [3];
    logic m_st [3], m_dw [3], m_al [3], m_le [3];

    always #5 clk = ~clk;

    always_comb begin
        obs[0] = o0;
        obs[1] = o1;
        obs[2] = o2;
    end

    bcd_rtc_core #(.CLK_DIV(4), .HOUR_12(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .load(load), .set_time(set_time), .set_pm(set_pm),
        .alarm_time(alarm_time), .alarm_pm(alarm_pm), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
        .hour1(o0[28:25]), .hour0(o0[24:21]), .min1(o0[20:17]), .min0(o0[16:13]),
        .sec1(o0[12:9]), .sec0(o0[8:5]), .pm(o0[4]), .sec_tick(o0[3]), .day_wrap(o0[2]),
        .alarm(o0[1]), .load_err(o0[0]));
    bcd_rtc_core #(.CLK_DIV(1), .HOUR_12(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .load(load), .set_time(set_time), .set_pm(set_pm),
        .alarm_time(alarm_time), .alarm_pm(alarm_pm), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
        .hour1(o1[28:25]), .hour0(o1[24:21]), .min1(o1[20:17]), .min0(o1[16:13]),
        .sec1(o1[12:9]), .sec0(o1[8:5]), .pm(o1[4]), .sec_tick(o1[3]), .day_wrap(o1[2]),
        .alarm(o1[1]), .load_err(o1[0]));
    bcd_rtc_core #(.CLK_DIV(1), .HOUR_12(1)) u_c (
        .clk(clk), .rst(rst), .en(en), .load(load), .set_time(set_time), .set_pm(set_pm),
        .alarm_time(alarm_time), .alarm_pm(alarm_pm), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
        .hour1(o2[28:25]), .hour0(o2[24:21]), .min1(o2[20:17]), .min0(o2[16:13]),
        .sec1(o2[12:9]), .sec0(o2[8:5]), .pm(o2[4]), .sec_tick(o2[3]), .day_wrap(o2[2]),
        .alarm(o2[1]), .load_err(o2[0]));

    // Displayed {h1,h0,m1,m0,s1,s0,pm} for a seconds-of-day value.
    function automatic logic [24:0] disp(input int k, input int t);
        int h, mi, s, hh;
        logic p;
        h  = t / 3600;
        mi = (t / 60) % 60;
        s  = t % 60;
        p  = 1'b0;
        hh = h;
        if (k == 2) begin
            p  = (h >= 12);
            hh = h % 12;
            if (hh == 0) hh = 12;
        end
        return {4'(hh / 10), 4'(hh % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10), p};
    endfunction

    function automatic logic load_ok(input int k, input logic [23:0] t);
        int hh;
        if (t[23:20] > 9 || t[19:16] > 9 || t[15:12] > 5 || t[11:8] > 9 ||
            t[7:4] > 5 || t[3:0] > 9) return 1'b0;
        hh = int'(t[23:20]) * 10 + int'(t[19:16]);
        if (k == 2) return (hh >= 1 && hh <= 12);
        return (hh <= 23);
    endfunction

    function automatic int load_tod(input int k, input logic [23:0] t, input logic p);
        int hh, mi, s;
        hh = int'(t[23:20]) * 10 + int'(t[19:16]);
        mi = int'(t[15:12]) * 10 + int'(t[11:8]);
        s  = int'(t[7:4]) * 10 + int'(t[3:0]);
        if (k == 2) hh = (hh % 12) + (p ? 12 : 0);
        return hh * 3600 + mi * 60 + s;
    endfunction

    function automatic logic [28:0] exp_of(input int k);
        return {disp(k, m_tod[k]), m_st[k], m_dw[k], m_al[k], m_le[k]};
    endfunction

    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            int div;
            logic tk, hit;
            logic [24:0] dd;
            div = (k == 0) ? 4 : 1;
            if (rst) begin
                m_tod[k] = 0; m_cnt[k] = 0;
                m_st[k] = 0; m_dw[k] = 0; m_al[k] = 0; m_le[k] = 0;
            end else begin
                m_st[k] = 0; m_dw[k] = 0; m_le[k] = 0;
                tk = en && (m_cnt[k] == div - 1);
                if (load && load_ok(k, set_time)) begin
                    m_tod[k] = load_tod(k, set_time, set_pm);
                    m_cnt[k] = 0;
                    if (alarm_ack || !alarm_en) m_al[k] = 0;
                end else begin
                    if (load) m_le[k] = 1;
                    if (en) m_cnt[k] = tk ? 0 : m_cnt[k] + 1;
                    hit = 0;
                    if (tk) begin
                        m_tod[k] = (m_tod[k] + 1) % 86400;
                        m_st[k]  = 1;
                        m_dw[k]  = (m_tod[k] == 0);
                        dd  = disp(k, m_tod[k]);
                        hit = alarm_en && (m_tod[k] % 60 == 0) && (dd[24:9] == alarm_time) &&
                              (k != 2 || dd[0] == alarm_pm);
                    end
                    if (hit) m_al[k] = 1;
                    else if (alarm_ack || !alarm_en) m_al[k] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 0; en = 0; load = 0; set_time = '0; set_pm = 0; alarm_ack = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== exp_of(k)) begin
                errors++;
                $display("FAIL reset dut%0d got %h want %h", k, obs[k], exp_of(k));
            end
        end
        checks++;
        if (obs[2][28:4] !== {24'h120000, 1'b0}) begin
            errors++;
            $display("FAIL reset_12h got %h want %h", obs[2][28:4], {24'h120000, 1'b0});
        end
    endtask

    task automatic test_prescaler();
        rst = 1; step(); rst = 0; en = 1;
        for (int c = 1; c <= 22; c++) begin
            if (c == 13) en = 0;
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_of(k)) begin
                    errors++;
                    $display("FAIL prescaler dut%0d cyc %0d got %h want %h", k, c, obs[k], exp_of(k));
                end
            end
            checks++;
            if (obs[0][3] !== (c <= 12 && c % 4 == 0)) begin
                errors++;
                $display("FAIL prescaler_tick cyc %0d got %b want %b", c, obs[0][3], (c <= 12 && c % 4 == 0));
            end
        end
        checks++;
        if (obs[0][28:5] !== 24'h000003) begin
            errors++;
            $display("FAIL prescaler_time got %h want 000003", obs[0][28:5]);
        end
        idle();
    endtask

    task automatic test_rollover();
        logic [23:0] want [5];
        logic        dw   [5];
        want = '{24'h235958, 24'h235959, 24'h000000, 24'h000001, 24'h100000};
        dw   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 5; c++) begin
            idle();
            if (c == 0) begin load = 1; set_time = 24'h235958; end
            else if (c == 4) begin
                load = 1; set_time = 24'h095959; step();
                load = 0; en = 1;
            end else en = 1;
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_of(k)) begin
                    errors++;
                    $display("FAIL rollover dut%0d step %0d got %h want %h", k, c, obs[k], exp_of(k));
                end
            end
            checks++;
            if (obs[1][28:5] !== want[c] || obs[1][2] !== dw[c]) begin
                errors++;
                $display("FAIL rollover_24h step %0d got %h/%b want %h/%b", c, obs[1][28:5], obs[1][2], want[c], dw[c]);
            end
        end
        idle();
    endtask

    task automatic test_12h();
        logic [23:0] lt [3], wt [3];
        logic        lp [3], wp [3], wd [3];
        lt = '{24'h115959, 24'h125959, 24'h115959};
        lp = '{1'b0, 1'b1, 1'b1};
        wt = '{24'h120000, 24'h010000, 24'h120000};
        wp = '{1'b1, 1'b1, 1'b0};
        wd = '{1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 3; c++) begin
            idle(); load = 1; set_time = lt[c]; set_pm = lp[c];
            step();
            idle(); en = 1;
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_of(k)) begin
                    errors++;
                    $display("FAIL hour12 dut%0d case %0d got %h want %h", k, c, obs[k], exp_of(k));
                end
            end
            checks++;
            if (obs[2][28:4] !== {wt[c], wp[c]} || obs[2][2] !== wd[c]) begin
                errors++;
                $display("FAIL hour12_wrap case %0d got %h/%b want %h/%b", c, obs[2][28:4], obs[2][2], {wt[c], wp[c]}, wd[c]);
            end
        end
        idle();
    endtask

    task automatic test_load_err();
        logic [23:0] lt [3];
        logic [2:0]  em [3];
        lt = '{24'h240000, 24'h006000, 24'h000000};
        em = '{3'b111, 3'b111, 3'b100};
        for (int c = 0; c < 3; c++) begin
            for (int ph = 0; ph < 2; ph++) begin
                idle();
                if (ph == 0) begin load = 1; set_time = lt[c]; end
                step();
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (obs[k] !== exp_of(k)) begin
                        errors++;
                        $display("FAIL load_err dut%0d case %0d got %h want %h", k, c, obs[k], exp_of(k));
                    end
                    checks++;
                    if (obs[k][0] !== (ph == 0 && em[c][k])) begin
                        errors++;
                        $display("FAIL load_err_pulse dut%0d case %0d ph %0d got %b want %b", k, c, ph, obs[k][0], (ph == 0 && em[c][k]));
                    end
                end
            end
        end
        idle();
    endtask

    task automatic test_load_tick();
        rst = 1; step(); rst = 0; en = 1;
        for (int c = 0; c < 8; c++) begin
            load = (c == 3); set_time = 24'h101010;
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_of(k)) begin
                    errors++;
                    $display("FAIL load_tick dut%0d cyc %0d got %h want %h", k, c, obs[k], exp_of(k));
                end
            end
            checks++;
            if (obs[0][3] !== (c == 7)) begin
                errors++;
                $display("FAIL load_tick_pulse cyc %0d got %b want %b", c, obs[0][3], (c == 7));
            end
        end
        checks++;
        if (obs[0][28:5] !== 24'h101011) begin
            errors++;
            $display("FAIL load_tick_time got %h want 101011", obs[0][28:5]);
        end
        idle();
    endtask

    task automatic test_alarm();
        // per cycle: load value (0 = none), en, ack, expected alarm of dut1
        logic [23:0] lt [10];
        logic        e  [10], a [10], wa [10];
        lt = '{24'h072959, 0, 0, 0, 0, 24'h073000, 24'h072959, 0, 0, 0};
        e  = '{0, 1, 1, 1, 0, 0, 0, 1, 0, 0};
        a  = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 1};
        wa = '{0, 1, 1, 1, 0, 0, 0, 1, 1, 0};
        alarm_time = 16'h0730; alarm_pm = 0; alarm_en = 1;
        for (int c = 0; c < 10; c++) begin
            idle();
            load = (lt[c] != 0); set_time = lt[c]; en = e[c]; alarm_ack = a[c];
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_of(k)) begin
                    errors++;
                    $display("FAIL alarm dut%0d cyc %0d got %h want %h", k, c, obs[k], exp_of(k));
                end
            end
            checks++;
            if (obs[1][1] !== wa[c] || obs[2][1] !== wa[c]) begin
                errors++;
                $display("FAIL alarm_flag cyc %0d got %b%b want %b", c, obs[1][1], obs[2][1], wa[c]);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        alarm_time = 16'h1345; alarm_en = 1;
        load = 1; set_time = 24'h134459; step();
        load = 0; en = 1;
        for (int c = 0; c < 28; c++) step();
        en = 0; step();
        checks++;
        if (obs[1][28:5] !== 24'h134527 || obs[1][1] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got %h/%b want 134527/1", obs[1][28:5], obs[1][1]);
        end
        rst = 1; load = 1; set_time = 24'h101010; en = 1;
        step();
        rst = 0; load = 0;
        checks++;
        if (obs[1] !== 29'h0) begin
            errors++;
            $display("FAIL reset_mid got %h want 0", obs[1]);
        end
        for (int c = 1; c <= 4; c++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_of(k)) begin
                    errors++;
                    $display("FAIL reset_mid dut%0d cyc %0d got %h want %h", k, c, obs[k], exp_of(k));
                end
            end
            checks++;
            if (obs[0][3] !== (c == 4)) begin
                errors++;
                $display("FAIL reset_mid_prescaler cyc %0d got %b want %b", c, obs[0][3], (c == 4));
            end
        end
        idle();
    endtask

    task automatic test_random();
        logic [24:0] nx;
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            en        = ($urandom_range(0, 3) != 0);
            load      = ($urandom_range(0, 15) == 0);
            set_pm    = 1'($urandom_range(0, 1));
            alarm_en  = ($urandom_range(0, 15) != 0);
            alarm_ack = ($urandom_range(0, 31) == 0);
            set_time  = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 6)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
            if ($urandom_range(0, 1) == 1) set_time[7:0] = 8'h59;
            if (c % 50 == 0) begin
                nx = disp(1 + (c / 50) % 2, (m_tod[1 + (c / 50) % 2] + 60) % 86400);
                alarm_time = nx[24:9];
                alarm_pm   = nx[0];
            end
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_of(k)) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d got %h want %h", k, c, obs[k], exp_of(k));
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        alarm_time = '0; alarm_pm = 0; alarm_en = 0;
        test_reset();
        test_prescaler();
        test_rollover();
        test_12h();
        test_load_err();
        test_load_tick();
        test_alarm();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bcd_rtc_core.md
Name: bcd_rtc_core

Overview:
Parametrised BCD real-time clock core. It is the successor to the free-running 24 h BCD counter.
- Adds an internal prescaler, so one "second" equals CLK_DIV clocks.
- Adds a count enable, a validated time-set port, a 12 h/24 h build mode, a day-wrap pulse and an hh:mm alarm with acknowledge.
- Sits between the system clock and the display/alarm logic; the six BCD digit outputs feed the 7-segment driver directly.

Parameters:
CLK_DIV, 1, clk cycles per second tick; legal range 1 to 2^26; 1 gives a tick on every enabled cycle.
HOUR_12, 0, 0 = 24 h mode (hours 00-23); 1 = 12 h mode (hours 01-12 plus pm flag).

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous reset, active-high.
en  in  1  count enable; when low, prescaler and time hold.
load  in  1  one-cycle request to load set_time/set_pm.
set_time  in  24  BCD {h1,h0,m1,m0,s1,s0}, 4 bits per digit.
set_pm  in  1  pm value for load; ignored when HOUR_12=0.
alarm_time  in  16  BCD {h1,h0,m1,m0}.
alarm_pm  in  1  alarm pm qualifier; ignored when HOUR_12=0.
alarm_en  in  1  alarm arm.
alarm_ack  in  1  clears alarm.
sec1, sec0, min1, min0, hour1, hour0  out  4 each  current time, BCD.
pm  out  1  pm flag; constant 0 when HOUR_12=0.
sec_tick  out  1  one-cycle pulse marking the cycle in which a new second is first visible.
day_wrap  out  1  one-cycle pulse on the midnight rollover.
alarm  out  1  sticky alarm flag.
load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - 24 h mode: time 00:00:00.
  - 12 h mode: time 12:00:00 with pm=0.
  - prescaler=0; sec_tick, day_wrap, alarm and load_err all 0.
- Priority on each edge: rst > load > tick.
- Prescaler:
  - Counter of width max(1, clog2(CLK_DIV)).
  - When en=1, it counts 0..CLK_DIV-1; the internal tick is asserted when en=1 and count==CLK_DIV-1, and the counter returns to 0.
  - When en=0, the counter holds and no tick is produced.
- Tick update:
  - On the tick edge, time advances by one second and sec_tick=1 in the following cycle, coincident with the new digit values.
  - Latency from the tick edge to a visible digit change is 0 extra cycles beyond the registering edge.
- Digit cascade:
  - s0 runs 9->0 with a carry into s1; s1 runs 5->0 with a carry into minutes.
  - Minutes follow the same pattern as seconds and carry into hours.
- 24 h mode: 23:59:59 -> 00:00:00; day_wrap pulses on that edge.
- 12 h mode:
  - 11:59:59 -> 12:00:00 and pm toggles.
  - 12:59:59 -> 01:00:00 with no pm change.
  - day_wrap pulses on the 11:59:59 pm=1 -> 12:00:00 pm=0 transition only.
- Load:
  - When load=1 (and rst=0), set_time is validated:
    - every digit must be <= 9; s1 and m1 must be <= 5;
    - 24 h mode: hours 00-23;
    - 12 h mode: hours 01-12.
  - Valid load: time and pm are written, the prescaler clears to 0, and there is no tick, no sec_tick and no alarm evaluation that cycle. This holds even if a tick coincided.
  - Invalid load: time is unchanged, load_err=1 for one cycle, and the prescaler proceeds normally (a coinciding tick still counts).
- Alarm:
  - Alarm set condition, evaluated on tick edges only, against the new time:
    - alarm_en=1;
    - new seconds == 00;
    - new {h1,h0,m1,m0} == alarm_time;
    - in 12 h mode, new pm == alarm_pm.
  - Alarm clear: alarm_ack=1 or alarm_en=0. Set wins if set and clear coincide.
  - A loaded time never sets the alarm.
- Registering: all outputs are registered and there are no combinational paths from inputs to outputs.
- Mid-operation rst: returns everything to reset values on the next edge, regardless of load or tick.
- Stored invalid states are unreachable. The design may resolve digits > 9 arbitrarily, but this is not verified.

Test Plan:
- Prescaler (CLK_DIV=4, HOUR_12=0): rst, then en=1 for 12 cycles -> time 00:00:03; sec_tick high exactly on cycles 4, 8, 12; en=0 for 10 cycles -> no change.
- 24 h rollover (CLK_DIV=1): load 23:59:58, then en=1 -> 23:59:59, then 00:00:00 with day_wrap=1 for one cycle; 09:59:59 -> 10:00:00.
- 12 h mode (HOUR_12=1):
  - load 11:59:59 pm=0, tick -> 12:00:00 pm=1, day_wrap=0;
  - load 12:59:59 pm=1, tick -> 01:00:00 pm=1;
  - load 11:59:59 pm=1, tick -> 12:00:00 pm=0, day_wrap=1.
- Load validation:
  - load 24:00:00 in 24 h -> load_err pulse, time unchanged;
  - load 00:60:00 -> load_err;
  - load 00:00:00 in 12 h -> load_err;
  - load coincident with a tick (CLK_DIV=4, load on count==3) -> loaded value shown, no sec_tick, next tick 4 cycles later.
- Alarm:
  - alarm_time=07:30, alarm_en=1, load 07:29:59, tick -> alarm=1 at 07:30:00; stays high across later ticks; alarm_ack -> 0 next cycle;
  - load 07:30:00 directly -> alarm stays 0;
  - ack coincident with a matching tick -> alarm=1.
- Reset mid-run: at 13:45:27 with alarm=1, assert rst together with load -> 00:00:00, alarm=0, load ignored, prescaler=0.
